audio_dac_serializer: RTL and testbench

- Transmit-side counterpart to the record/playback controller: it accepts the `{left, right}` sample pairs issued with the `write_audio_out` / `audio_out_allowed` handshake.
- Buffers the pairs in a small FIFO.
- Serializes them MSB-first onto `AUD_DACDAT` in I2S format, timed by the codec-mastered `AUD_BCLK` / `AUD_DACLRCK`.
- Sits between the playback FSM and the WM8731 pins and replaces the DAC path of the vendor audio controller.

---
 rtl/audio_dac_serializer_pkg.sv | 26 ++
 rtl/audio_dac_serializer_if.sv | 27 ++
 rtl/audio_dac_serializer_fifo.sv | 73 +++++++
 rtl/audio_dac_serializer.sv | 158 +++++++++++++++
 tb/tb_audio_dac_serializer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/audio_dac_serializer_pkg.sv
// Shared definitions for the I2S DAC serializer: default sample width, FSM
// encodings, the stereo pair type and the FIFO level-width helper.
package audio_dac_pkg;

  localparam int AUD_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } dac_state_e;

  localparam logic [1:0] ST_SYNC_WAIT = SYNC_WAIT;
  localparam logic [1:0] ST_LEFT      = LEFT;
  localparam logic [1:0] ST_RIGHT     = RIGHT;

  typedef struct packed {
    logic [AUD_DATA_WIDTH-1:0] left;
    logic [AUD_DATA_WIDTH-1:0] right;
  } audio_pair_t;

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/audio_dac_serializer_if.sv
// Sample-pair push handshake between the playback FSM (master) and the
// DAC serializer (slave).
interface audio_dac_serializer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] left_channel_audio_out;
  logic [DATA_WIDTH-1:0] right_channel_audio_out;
  logic                  write_audio_out;
  logic                  clear_audio_out_memory;
  logic                  audio_out_allowed;

  modport master (
    output left_channel_audio_out,
    output right_channel_audio_out,
    output write_audio_out,
    output clear_audio_out_memory,
    input  audio_out_allowed
  );

  modport slave (
    input  left_channel_audio_out,
    input  right_channel_audio_out,
    input  write_audio_out,
    input  clear_audio_out_memory,
    output audio_out_allowed
  );
endinterface

// File: rtl/audio_dac_serializer_fifo.sv
// Synchronous stereo-pair FIFO with push, pop, flush and an occupancy count;
// a push arriving together with a flush is dropped.
module audio_pair_fifo
  import audio_dac_pkg::*;
#(
  parameter  int WIDTH = 2 * AUD_DATA_WIDTH,
  parameter  int DEPTH = 8,
  localparam int LW    = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign push_ok   = push_i && !full_o && !clear_i;
  assign pop_ok    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the level count gates every read that matters.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer: buffers {left,right} pairs and shifts them MSB-first onto
// AUD_DACDAT on codec BCLK falls. Define AUDIO_DAC_HOLD_LAST_EN to replay the last pair on underrun.
//
// state     | meaning
// SYNC_WAIT | output held 0 until the first left-frame start (LRCK 1->0)
// LEFT      | shifting the left word of the popped pair
// RIGHT     | shifting the right word held from the same pair
module audio_dac_serializer
  import audio_dac_pkg::*;
#(
  parameter  int DATA_WIDTH = AUD_DATA_WIDTH,
  parameter  int FIFO_DEPTH = 8,
  localparam int LW         = level_width(FIFO_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  audio_dac_serializer_if.slave        aud_if,
  input  logic                         AUD_BCLK,
  input  logic                         AUD_DACLRCK,
  output logic                         AUD_DACDAT,
  output logic [LW-1:0]                fifo_level
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int PW = 2 * DATA_WIDTH;

  logic                  bclk_meta_q, bclk_sync_q, bclk_prev_q;
  logic                  lrck_meta_q, lrck_sync_q, lrck_prev_q;
  logic                  bclk_fall, lr_fall, lr_rise;
  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] right_hold_q, right_hold_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  dacdat_q, dacdat_d;
  logic                  pop, fifo_full, fifo_empty;
  logic [PW-1:0]         fifo_rd_data, next_pair;
  logic [LW-1:0]         level;

  audio_pair_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (aud_if.write_audio_out),
    .pop_i     (pop),
    .clear_i   (aud_if.clear_audio_out_memory),
    .wr_data_i ({aud_if.left_channel_audio_out, aud_if.right_channel_audio_out}),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

  assign aud_if.audio_out_allowed = ~fifo_full;
  assign fifo_level               = level;
  assign AUD_DACDAT               = dacdat_q;

  // Codec clocks are asynchronous to clk; LRCK is only interpreted at BCLK falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bclk_meta_q <= 1'b0;
      bclk_sync_q <= 1'b0;
      bclk_prev_q <= 1'b0;
      lrck_meta_q <= 1'b0;
      lrck_sync_q <= 1'b0;
      lrck_prev_q <= 1'b0;
    end else begin
      bclk_meta_q <= AUD_BCLK;
      bclk_sync_q <= bclk_meta_q;
      bclk_prev_q <= bclk_sync_q;
      lrck_meta_q <= AUD_DACLRCK;
      lrck_sync_q <= lrck_meta_q;
      if (bclk_fall) lrck_prev_q <= lrck_sync_q;
    end
  end

  assign bclk_fall = bclk_prev_q & ~bclk_sync_q;
  assign lr_fall   = bclk_fall & lrck_prev_q & ~lrck_sync_q;
  assign lr_rise   = bclk_fall & ~lrck_prev_q & lrck_sync_q;

`ifdef AUDIO_DAC_HOLD_LAST_EN
  logic [PW-1:0] last_pair_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_pair_q <= '0;
    end else if (aud_if.clear_audio_out_memory) begin
      last_pair_q <= '0;
    end else if (pop && !fifo_empty) begin
      last_pair_q <= fifo_rd_data;
    end
  end

  assign next_pair = fifo_empty ? last_pair_q : fifo_rd_data;
`else
  assign next_pair = fifo_empty ? '0 : fifo_rd_data;
`endif

  // The fall that detects an LRCK edge emits the I2S delay bit (0) and loads the word.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    right_hold_d = right_hold_q;
    bit_cnt_d    = bit_cnt_q;
    dacdat_d     = dacdat_q;
    pop          = 1'b0;
    if (bclk_fall) begin
      dacdat_d = 1'b0;
      case (state_q)
        ST_SYNC_WAIT: begin
          if (lr_fall) begin
            pop          = 1'b1;
            shift_d      = next_pair[PW-1 -: DATA_WIDTH];
            right_hold_d = next_pair[DATA_WIDTH-1:0];
            bit_cnt_d    = CW'(DATA_WIDTH);
            state_d      = ST_LEFT;
          end
        end
        ST_LEFT, ST_RIGHT: begin
          if (lr_fall) begin
            pop          = 1'b1;
            shift_d      = next_pair[PW-1 -: DATA_WIDTH];
            right_hold_d = next_pair[DATA_WIDTH-1:0];
            bit_cnt_d    = CW'(DATA_WIDTH);
            state_d      = ST_LEFT;
          end else if (lr_rise) begin
            shift_d   = right_hold_q;
            bit_cnt_d = CW'(DATA_WIDTH);
            state_d   = ST_RIGHT;
          end else if (bit_cnt_q != '0) begin
            dacdat_d  = shift_q[DATA_WIDTH-1];
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q - CW'(1);
          end
        end
        default: state_d = ST_SYNC_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_SYNC_WAIT;
      shift_q      <= '0;
      right_hold_q <= '0;
      bit_cnt_q    <= '0;
      dacdat_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      right_hold_q <= right_hold_d;
      bit_cnt_q    <= bit_cnt_d;
      dacdat_q     <= dacdat_d;
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: drives BCLK/LRCK as 32-slot I2S halves
// and compares every captured half-frame against hand-computed words.
module tb_audio_dac_serializer;
  import audio_dac_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        AUD_BCLK = 1'b1;
  logic        AUD_DACLRCK = 1'b1;
  logic        AUD_DACDAT;
  logic [3:0]  fifo_level;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] pp_left = '0;
  logic [15:0] pp_right = '0;

  audio_dac_serializer_if #(.DATA_WIDTH(16)) aud_if ();

  audio_dac_serializer #(
    .DATA_WIDTH (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .aud_if      (aud_if),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (AUD_DACDAT),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected 32-slot half: delay bit, 16 data bits MSB first, then zero padding.
  function automatic logic [31:0] slotw(input logic [15:0] w);
    return {1'b0, w, 15'b0};
  endfunction

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    aud_if.left_channel_audio_out  = l;
    aud_if.right_channel_audio_out = r;
    aud_if.write_audio_out         = 1'b1;
    @(negedge clk);
    aud_if.write_audio_out = 1'b0;
  endtask

  // One BCLK slot = 4 clk low + 4 clk high; DACDAT sampled just before the next fall.
  task automatic half(input logic lr, input int nslots, input logic pp, output logic [31:0] bits);
    bits = '0;
    for (int s = 0; s < nslots; s++) begin
      AUD_BCLK = 1'b0;
      if (s == 0) AUD_DACLRCK = lr;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (pp && s == 0 && k == 1) begin
          aud_if.left_channel_audio_out  = pp_left;
          aud_if.right_channel_audio_out = pp_right;
          aud_if.write_audio_out         = 1'b1;
        end
        if (pp && s == 0 && k == 2) begin
          aud_if.write_audio_out = 1'b0;
          chk("pushpop_level", 32'(fifo_level), 32'd3);
        end
      end
      AUD_BCLK = 1'b1;
      repeat (4) @(negedge clk);
      bits = {bits[30:0], AUD_DACDAT};
    end
  endtask

  task automatic frame(input logic pp, output logic [31:0] l, output logic [31:0] r);
    half(1'b0, 32, pp, l);
    half(1'b1, 32, 1'b0, r);
  endtask

  initial begin
    logic [31:0] l, r, b1, b2;
    logic [15:0] w;

    aud_if.left_channel_audio_out  = '0;
    aud_if.right_channel_audio_out = '0;
    aud_if.write_audio_out         = 1'b0;
    aud_if.clear_audio_out_memory  = 1'b0;

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_allowed", 32'(aud_if.audio_out_allowed), 32'd1);
    chk("rst_dacdat", 32'(AUD_DACDAT), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Idle with LRCK high: SYNC_WAIT keeps the line low.
    half(1'b1, 4, 1'b0, b1);
    chk("sync_idle", b1, 32'd0);

    push(16'hA5F0, 16'h0F3C);
    chk("basic_level_push", 32'(fifo_level), 32'd1);
    frame(1'b0, l, r);
    chk("basic_left", l, slotw(16'hA5F0));
    chk("basic_right", r, slotw(16'h0F3C));
    chk("basic_level_pop", 32'(fifo_level), 32'd0);

    // Fill with BCLK stopped; 9th push must be refused.
    for (int i = 0; i < 8; i++) begin
      w = 16'(16'h1111 * (i + 1));
      push(w, ~w);
      if (i == 6) chk("fill_allowed7", 32'(aud_if.audio_out_allowed), 32'd1);
    end
    chk("full_allowed", 32'(aud_if.audio_out_allowed), 32'd0);
    chk("full_level", 32'(fifo_level), 32'd8);
    push(16'hDEAD, 16'hBEEF);
    chk("full_ignore_level", 32'(fifo_level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      w = 16'(16'h1111 * (i + 1));
      frame(1'b0, l, r);
      chk($sformatf("drain_left%0d", i), l, slotw(w));
      chk($sformatf("drain_right%0d", i), r, slotw(~w));
    end
    frame(1'b0, l, r);
`ifdef AUDIO_DAC_HOLD_LAST_EN
    chk("drain_extra_left", l, slotw(16'h8888));
    chk("drain_extra_right", r, slotw(16'h7777));
`else
    chk("drain_extra_left", l, 32'd0);
    chk("drain_extra_right", r, 32'd0);
`endif

    push(16'h7FFF, 16'h8000);
    frame(1'b0, l, r);
    chk("under_f1_left", l, slotw(16'h7FFF));
    chk("under_f1_right", r, slotw(16'h8000));
    frame(1'b0, l, r);
`ifdef AUDIO_DAC_HOLD_LAST_EN
    chk("under_f2_left", l, slotw(16'h7FFF));
    chk("under_f2_right", r, slotw(16'h8000));
`else
    chk("under_f2_left", l, 32'd0);
    chk("under_f2_right", r, 32'd0);
`endif

    // Reset in the middle of a right half while DACDAT is driving a 1.
    push(16'h8001, 16'h4002);
    half(1'b0, 32, 1'b0, b1);
    chk("mid_left", b1, slotw(16'h8001));
    half(1'b1, 3, 1'b0, b1);
    chk("mid_right_partial", b1, 32'h1);
    push(16'h1111, 16'h2222);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_dacdat", 32'(AUD_DACDAT), 32'd0);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    chk("midrst_allowed", 32'(aud_if.audio_out_allowed), 32'd1);
    rst = 1'b1;
    push(16'hC3A5, 16'h5A3C);
    half(1'b1, 29, 1'b0, b1);
    chk("midrst_quiet", b1, 32'd0);
    frame(1'b0, l, r);
    chk("midrst_left", l, slotw(16'hC3A5));
    chk("midrst_right", r, slotw(16'h5A3C));

    // Flush with 5 queued while the left word is shifting; a same-cycle push is dropped.
    for (int i = 0; i < 5; i++) push(16'(16'hA000 + i), 16'(16'h0500 + i));
    chk("clr_level5", 32'(fifo_level), 32'd5);
    half(1'b0, 8, 1'b0, b1);
    chk("clr_level4", 32'(fifo_level), 32'd4);
    aud_if.clear_audio_out_memory  = 1'b1;
    aud_if.write_audio_out         = 1'b1;
    aud_if.left_channel_audio_out  = 16'hFFFF;
    aud_if.right_channel_audio_out = 16'hFFFF;
    @(negedge clk);
    aud_if.clear_audio_out_memory = 1'b0;
    aud_if.write_audio_out        = 1'b0;
    chk("clr_level0", 32'(fifo_level), 32'd0);
    half(1'b0, 24, 1'b0, b2);
    chk("clr_left_completes", {b1[7:0], b2[23:0]}, slotw(16'hA000));
    half(1'b1, 32, 1'b0, r);
    chk("clr_right", r, slotw(16'h0500));
    frame(1'b0, l, r);
    chk("clr_under_left", l, 32'd0);
    chk("clr_under_right", r, 32'd0);

    // Push lands in the same clk as each frame-start pop at level 3.
    for (int i = 0; i < 3; i++) push(16'(16'h3C00 + i), 16'(16'hC300 + i));
    chk("pp_level_start", 32'(fifo_level), 32'd3);
    for (int k = 0; k < 4; k++) begin
      pp_left  = 16'(16'h3C00 + k + 3);
      pp_right = 16'(16'hC300 + k + 3);
      frame(1'b1, l, r);
      chk($sformatf("pp_left%0d", k), l, slotw(16'(16'h3C00 + k)));
      chk($sformatf("pp_right%0d", k), r, slotw(16'(16'hC300 + k)));
    end
    chk("pp_level_end", 32'(fifo_level), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
